psum_gbf: RTL
=============

Name: psum_gbf

Overview:
Two-bank partial-sum global buffer. It is the storage end of the psum GBF interface that su_adder drives.
- su_adder side: accepts su_adder line writes, zero-init writes and accumulate reads.
- Drain side: on conv_finish, streams a completed bank out over a valid/ready port to the output path while su_adder keeps working in the other bank.

Parameters:
GBF_DATA_BITWIDTH, 512, width of one psum line
GBF_ADDR_BITWIDTH, 5, line address width per bank
DEPTH, 32, lines per bank (must equal 2**GBF_ADDR_BITWIDTH)

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
psum_gbf_w_en  input  1  su-side line write strobe
psum_gbf_w_addr  input  GBF_ADDR_BITWIDTH  su-side write address
psum_gbf_w_num  input  1  bank select for all su-side accesses (write, read, init)
w_data  input  GBF_DATA_BITWIDTH  su-side write data (su_adder out_data)
psum_gbf_r_en  input  1  su-side read strobe
psum_gbf_r_addr  input  GBF_ADDR_BITWIDTH  su-side read address
psum_gbf_w_en_for_init  input  1  zero-write strobe
psum_gbf_w_addr_for_init  input  GBF_ADDR_BITWIDTH  zero-write address
r_data  output  GBF_DATA_BITWIDTH  su-side read data
r_valid  output  1  r_data valid pulse
conv_finish  input  1  start-drain pulse; drains bank psum_gbf_w_num
drain_len  input  GBF_ADDR_BITWIDTH+1  lines to drain, sampled at conv_finish; 0 means DEPTH
drain_data  output  GBF_DATA_BITWIDTH  drained line
drain_valid  output  1  drain_data valid
drain_ready  input  1  consumer accept
drain_done  output  1  one-cycle pulse after the last line is accepted
busy  output  1  drain in progress
conflict  output  1  sticky error flag

Behaviour:
Reset values: r_data=0, r_valid=0, drain_data=0, drain_valid=0, drain_done=0, busy=0, conflict=0, FSM=IDLE.
- Memory contents are not cleared by reset.
- Reset in any state aborts a drain on the next edge.

su-side read:
- Synchronous, latency 1: r_en at cycle N gives r_data and r_valid=1 at N+1.
- r_data holds its value when no read is in progress.
- A read and a write to the same bank/address in the same cycle returns the old data (read-before-write).

su-side write priority, same bank and address in the same cycle: psum_gbf_w_en beats w_en_for_init, so data wins over zero.

Drain FSM (states IDLE, FETCH, SEND, DONE):
- IDLE: on conv_finish, latch bank=psum_gbf_w_num, len=(drain_len==0 ? DEPTH : drain_len), addr=0, busy=1, then go to FETCH.
- FETCH: one-cycle memory read of bank[addr], then SEND.
- SEND: drain_valid=1 with drain_data stable until drain_ready is seen.
  - On accept, if addr==len-1 go to DONE; otherwise addr++ and go to FETCH.
  - Throughput is 1 line per 2 cycles.
- DONE: drain_done=1 for one cycle, busy=0, then IDLE.

Boundary rules:
- conv_finish while busy is ignored and sets conflict.
- Any su-side write or init targeting the latched drain bank while busy is dropped and sets conflict.
- Reads of the drain bank are allowed.
- Accesses to the other bank proceed normally during a drain.
- drain_ready asserted without drain_valid has no effect.
- conflict clears only on reset.

Optional Feature:
PSUM_GBF_CLEAR_ON_DRAIN_EN:
- Defined: on each accepted drain line, bank[addr] is written to 0 in the same cycle. A drained bank is therefore ready for the next accumulation without init writes. Internal clear writes do not set conflict.
- Undefined: the drain is read-only and contents persist after the drain.

Test Plan:
1. Write bank0 addr3 = {32{16'h0005}}, then r_en addr3 with w_num=0 one cycle later -> next cycle r_valid=1 and r_data={32{16'h0005}}. The same read with w_num=1 returns bank1 data instead.
2. Same cycle: w_en and w_en_for_init to addr7, w_data=all 16'h0001 -> a read of addr7 returns all 16'h0001. A read and a write to addr7 in the same cycle return the previous value.
3. Fill bank1 addr0..3 with line value k+1, conv_finish with w_num=1, drain_len=4, drain_ready=1 -> four lines with values 1,2,3,4, each valid for one cycle, every 2 cycles; drain_done pulses once; busy falls with it.
4. Drain with drain_ready low for 5 cycles at line 2 -> drain_valid stays high and drain_data stays stable; the sequence completes unchanged after ready rises.
5. During a bank0 drain, a su write to bank0 addr1 and a second conv_finish -> the write is dropped (addr1 unchanged after the drain) and conflict=1. A write to bank1 in the same window succeeds.
6. Assert reset in SEND of a drain_len=0 (32-line) drain -> next cycle all outputs are 0 and FSM=IDLE. With PSUM_GBF_CLEAR_ON_DRAIN_EN, a completed drain leaves reads of addr0..len-1 returning 0.

Source files
------------

// File: rtl/psum_gbf.sv
// psum_gbf: two-bank partial-sum global buffer.
// The su_adder side writes, zero-inits and reads lines in the bank selected by
// psum_gbf_w_num. A drain FSM streams one completed bank out over valid/ready
// while su_adder keeps working in the other bank.
// Optional build macro PSUM_GBF_CLEAR_ON_DRAIN_EN: zero each line as it is
// accepted by the drain consumer, so the bank needs no init pass before reuse.
module psum_gbf #(
  parameter int GBF_DATA_BITWIDTH = 512,
  parameter int GBF_ADDR_BITWIDTH = 5,
  parameter int DEPTH             = 32
)(
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         psum_gbf_w_en,
  input  logic [GBF_ADDR_BITWIDTH-1:0] psum_gbf_w_addr,
  input  logic                         psum_gbf_w_num,
  input  logic [GBF_DATA_BITWIDTH-1:0] w_data,
  input  logic                         psum_gbf_r_en,
  input  logic [GBF_ADDR_BITWIDTH-1:0] psum_gbf_r_addr,
  input  logic                         psum_gbf_w_en_for_init,
  input  logic [GBF_ADDR_BITWIDTH-1:0] psum_gbf_w_addr_for_init,
  output logic [GBF_DATA_BITWIDTH-1:0] r_data,
  output logic                         r_valid,
  input  logic                         conv_finish,
  input  logic [GBF_ADDR_BITWIDTH:0]   drain_len,
  output logic [GBF_DATA_BITWIDTH-1:0] drain_data,
  output logic                         drain_valid,
  input  logic                         drain_ready,
  output logic                         drain_done,
  output logic                         busy,
  output logic                         conflict
);
  localparam int LW = GBF_ADDR_BITWIDTH + 1;
  localparam logic [LW-1:0]                LEN_FULL = LW'(DEPTH);
  localparam logic [LW-1:0]                LEN_ONE  = LW'(1);
  localparam logic [GBF_ADDR_BITWIDTH-1:0] ADDR_ONE = GBF_ADDR_BITWIDTH'(1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_SEND  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [GBF_DATA_BITWIDTH-1:0] r_mem [2][DEPTH];

  logic [1:0]                   r_state;
  logic                         r_bank;
  logic [LW-1:0]                r_len;
  logic [GBF_ADDR_BITWIDTH-1:0] r_addr;
  logic [GBF_DATA_BITWIDTH-1:0] r_rdata;
  logic                         r_rvalid;
  logic [GBF_DATA_BITWIDTH-1:0] r_ddata;
  logic                         r_dvalid;
  logic                         r_ddone;
  logic                         r_busy;
  logic                         r_conflict;

  logic w_bank_hit;
  logic w_wr_ok;
  logic w_init_ok;
  logic w_accept;
  logic w_last;

  // su-side accesses to the bank being drained are blocked for the whole drain
  assign w_bank_hit = r_busy && (psum_gbf_w_num == r_bank);
  assign w_wr_ok    = psum_gbf_w_en && !w_bank_hit;
  assign w_init_ok  = psum_gbf_w_en_for_init && !w_bank_hit;
  // reset gates the handshake so an aborted drain never clears a line
  assign w_accept   = !reset && (r_state == S_SEND) && r_dvalid && drain_ready;
  assign w_last     = ({1'b0, r_addr} == (r_len - LEN_ONE));

  assign r_data      = r_rdata;
  assign r_valid     = r_rvalid;
  assign drain_data  = r_ddata;
  assign drain_valid = r_dvalid;
  assign drain_done  = r_ddone;
  assign busy        = r_busy;
  assign conflict    = r_conflict;

  // Line storage: init first, su write last, so data beats zero on a tie
  always_ff @(posedge clk) begin
    if (w_init_ok) r_mem[psum_gbf_w_num][psum_gbf_w_addr_for_init] <= '0;
    if (w_wr_ok)   r_mem[psum_gbf_w_num][psum_gbf_w_addr]          <= w_data;
`ifdef PSUM_GBF_CLEAR_ON_DRAIN_EN
    if (w_accept)  r_mem[r_bank][r_addr]                           <= '0;
`endif
  end

  // su-side read port: latency 1, old data on same-cycle write, data held when idle
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= psum_gbf_r_en;
      if (psum_gbf_r_en) r_rdata <= r_mem[psum_gbf_w_num][psum_gbf_r_addr];
    end
  end

  // Drain FSM: FETCH reads a line, SEND holds it until accepted (1 line / 2 cycles)
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_bank   <= 1'b0;
      r_len    <= '0;
      r_addr   <= '0;
      r_ddata  <= '0;
      r_dvalid <= 1'b0;
      r_ddone  <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_ddone <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (conv_finish) begin
            r_bank  <= psum_gbf_w_num;
            r_len   <= (drain_len == '0) ? LEN_FULL : drain_len;
            r_addr  <= '0;
            r_busy  <= 1'b1;
            r_state <= S_FETCH;
          end
        end
        S_FETCH: begin
          r_ddata  <= r_mem[r_bank][r_addr];
          r_dvalid <= 1'b1;
          r_state  <= S_SEND;
        end
        S_SEND: begin
          if (w_accept) begin
            r_dvalid <= 1'b0;
            if (w_last) begin
              r_ddone <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= S_DONE;
            end else begin
              r_addr  <= r_addr + ADDR_ONE;
              r_state <= S_FETCH;
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Sticky error: restart while busy, or su write/init aimed at the draining bank.
  // busy has already dropped in DONE, so a conv_finish there is simply ignored.
  always_ff @(posedge clk) begin
    if (reset) r_conflict <= 1'b0;
    else if ((conv_finish && r_busy) ||
             (psum_gbf_w_en && w_bank_hit) ||
             (psum_gbf_w_en_for_init && w_bank_hit)) r_conflict <= 1'b1;
  end

endmodule
